rtc_time_counter: RTL and testbench

//  Parametrised time-of-day counter: a prescaler derives a 1-second tick from clk,

---
 rtl/rtc_time_counter.sv | 164 ++++++++++++++++
 tb/tb_rtc_time_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_counter.sv
// ---------------------------------------------------------------------------
// rtc_time_counter
//
// Time-of-day counter. A prescaler divides clk down to a one-second tick,
// which drives cascaded seconds / minutes / hours counters. It also provides
// a synchronous time load with a range check, a run enable and an hh:mm
// alarm. This block is the single time base for the display and alarm logic.
//
// Parameters
//   DIV          clk cycles per second (>= 1)
//   SEC_PER_MIN  seconds per minute (2..64)
//   MIN_PER_HR   minutes per hour   (2..64)
//   HR_PER_DAY   hours per day      (2..32)
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-low reset
//   en         in   run enable; low freezes the prescaler and all counters
//   load       in   one-cycle request to load time from load_sec/min/hr
//   load_sec   in   [5:0] seconds value to load
//   load_min   in   [5:0] minutes value to load
//   load_hr    in   [4:0] hours value to load
//   alarm_en   in   alarm compare enable
//   alarm_min  in   [5:0] alarm minute
//   alarm_hr   in   [4:0] alarm hour
//   sec        out  [5:0] current seconds
//   min        out  [5:0] current minutes
//   hr         out  [4:0] current hours
//   sec_tick   out  pulse, sec advanced on this edge
//   min_tick   out  pulse, min advanced on this edge
//   hr_tick    out  pulse, hr advanced on this edge
//   day_tick   out  pulse, hr wrapped to 0 on this edge
//   alarm_hit  out  pulse, minute rollover landed on {alarm_hr, alarm_min}
//   load_err   out  pulse, load rejected (value out of range)
//
// Load handshake: load is a single-cycle request with no ready/ack. It is
// sampled on every edge regardless of en, and it takes priority over
// counting. A valid request updates the time and clears the prescaler. An
// invalid one leaves all state untouched, suppresses counting on that edge
// and answers with a one-cycle load_err.
// ---------------------------------------------------------------------------
module rtc_time_counter #(
    parameter int DIV         = 100,
    parameter int SEC_PER_MIN = 60,
    parameter int MIN_PER_HR  = 60,
    parameter int HR_PER_DAY  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hr,
    input  logic       alarm_en,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hr,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hr_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       load_err
);

    // With DIV=1 the prescaler is a single bit that never leaves 0, so a
    // second is counted on every enabled edge.
    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);
    localparam logic [5:0]     SEC_MAX = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0]     MIN_MAX = 6'(MIN_PER_HR - 1);
    localparam logic [4:0]     HR_MAX  = 5'(HR_PER_DAY - 1);

    logic [PW-1:0] pre;

    logic       pre_wrap;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic       load_ok;
    logic [5:0] next_min;
    logic [4:0] next_hr;
    logic [4:0] new_hr;
    logic       alarm_match;

    always_comb begin
        pre_wrap = (pre == PRE_MAX);
        sec_wrap = (sec == SEC_MAX);
        min_wrap = (min == MIN_MAX);
        hr_wrap  = (hr == HR_MAX);

        // One extra bit on each side so a maximum of 64 (or 32) still
        // compares correctly against a 6-bit (or 5-bit) load value.
        load_ok = ({1'b0, load_sec} < 7'(SEC_PER_MIN)) &&
                  ({1'b0, load_min} < 7'(MIN_PER_HR))  &&
                  ({1'b0, load_hr}  < 6'(HR_PER_DAY));

        next_min = min_wrap ? 6'd0 : min + 6'd1;
        next_hr  = hr_wrap  ? 5'd0 : hr + 5'd1;
        new_hr   = min_wrap ? next_hr : hr;

        // The alarm is compared against the time being entered on the minute
        // rollover. It is only consulted on that edge, so changes to alarm_*
        // part-way through a minute take effect at the next rollover.
        alarm_match = alarm_en && (new_hr == alarm_hr) && (next_min == alarm_min);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre       <= '0;
            sec       <= '0;
            min       <= '0;
            hr        <= '0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hr_tick   <= 1'b0;
            day_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hr_tick   <= 1'b0;
            day_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            load_err  <= 1'b0;

            if (load) begin
                if (load_ok) begin
                    sec <= load_sec;
                    min <= load_min;
                    hr  <= load_hr;
                    pre <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (!pre_wrap) begin
                    pre <= pre + PW'(1);
                end else begin
                    pre      <= '0;
                    sec_tick <= 1'b1;
                    if (!sec_wrap) begin
                        sec <= sec + 6'd1;
                    end else begin
                        sec       <= '0;
                        min       <= next_min;
                        min_tick  <= 1'b1;
                        alarm_hit <= alarm_match;
                        if (min_wrap) begin
                            hr       <= next_hr;
                            hr_tick  <= 1'b1;
                            day_tick <= hr_wrap;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_counter.sv
// ---------------------------------------------------------------------------
// tb_rtc_time_counter
//
// Runs two copies of rtc_time_counter side by side on shared inputs: one
// with DIV=4 and one with DIV=1. Both use the default 60/60/24 maxima.
// The reference model keeps the time of day as a count of seconds since
// midnight plus a prescale count. It derives sec/min/hr and every pulse
// from that count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_rtc_time_counter;

    localparam int SPM = 60;
    localparam int MPH = 60;
    localparam int HPD = 24;
    localparam int SPH = SPM * MPH;
    localparam int DAY = SPH * HPD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic       en        = 1'b0;
    logic       load      = 1'b0;
    logic [5:0] load_sec  = '0;
    logic [5:0] load_min  = '0;
    logic [4:0] load_hr   = '0;
    logic       alarm_en  = 1'b0;
    logic [5:0] alarm_min = '0;
    logic [4:0] alarm_hr  = '0;

    // ---------------- DUT outputs ----------------
    logic [5:0] sec_a, min_a, sec_b, min_b;
    logic [4:0] hr_a, hr_b;
    logic stk_a, mtk_a, htk_a, dtk_a, ahit_a, lerr_a;
    logic stk_b, mtk_b, htk_b, dtk_b, ahit_b, lerr_b;

    rtc_time_counter #(.DIV(4), .SEC_PER_MIN(SPM), .MIN_PER_HR(MPH), .HR_PER_DAY(HPD)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .sec(sec_a), .min(min_a), .hr(hr_a),
        .sec_tick(stk_a), .min_tick(mtk_a), .hr_tick(htk_a), .day_tick(dtk_a),
        .alarm_hit(ahit_a), .load_err(lerr_a)
    );

    rtc_time_counter #(.DIV(1), .SEC_PER_MIN(SPM), .MIN_PER_HR(MPH), .HR_PER_DAY(HPD)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .sec(sec_b), .min(min_b), .hr(hr_b),
        .sec_tick(stk_b), .min_tick(mtk_b), .hr_tick(htk_b), .day_tick(dtk_b),
        .alarm_hit(ahit_b), .load_err(lerr_b)
    );

    // ---------------- reference model ----------------
    int div_c[2] = '{4, 1};
    int t_m[2];     // seconds since midnight
    int pre_m[2];   // prescale count
    bit e_stk[2], e_mtk[2], e_htk[2], e_dtk[2], e_hit[2], e_lerr[2];

    int checks   = 0;
    int failures = 0;
    int hits_a   = 0;   // alarm pulses seen on the DIV=4 copy
    int stks_a   = 0;   // sec_tick pulses seen on the DIV=4 copy

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            t_m[k] = 0; pre_m[k] = 0;
            e_stk[k] = 0; e_mtk[k] = 0; e_htk[k] = 0;
            e_dtk[k] = 0; e_hit[k] = 0; e_lerr[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        e_stk[k] = 0; e_mtk[k] = 0; e_htk[k] = 0;
        e_dtk[k] = 0; e_hit[k] = 0; e_lerr[k] = 0;
        if (load) begin
            if (int'(load_sec) < SPM && int'(load_min) < MPH && int'(load_hr) < HPD) begin
                t_m[k]   = int'(load_hr) * SPH + int'(load_min) * SPM + int'(load_sec);
                pre_m[k] = 0;
            end else begin
                e_lerr[k] = 1;
            end
        end else if (en) begin
            if (pre_m[k] < div_c[k] - 1) begin
                pre_m[k]++;
            end else begin
                pre_m[k] = 0;
                t_m[k]   = (t_m[k] + 1) % DAY;
                e_stk[k] = 1;
                if (t_m[k] % SPM == 0) begin
                    e_mtk[k] = 1;
                    e_hit[k] = alarm_en && ((t_m[k] / SPM) % MPH == int'(alarm_min))
                                        && (t_m[k] / SPH == int'(alarm_hr));
                    if (t_m[k] % SPH == 0) begin
                        e_htk[k] = 1;
                        e_dtk[k] = (t_m[k] == 0);
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_sec", k),  k ? sec_b  : sec_a,  t_m[k] % SPM);
            chk($sformatf("d%0d_min", k),  k ? min_b  : min_a,  (t_m[k] / SPM) % MPH);
            chk($sformatf("d%0d_hr", k),   k ? hr_b   : hr_a,   t_m[k] / SPH);
            chk($sformatf("d%0d_stk", k),  k ? stk_b  : stk_a,  e_stk[k]);
            chk($sformatf("d%0d_mtk", k),  k ? mtk_b  : mtk_a,  e_mtk[k]);
            chk($sformatf("d%0d_htk", k),  k ? htk_b  : htk_a,  e_htk[k]);
            chk($sformatf("d%0d_dtk", k),  k ? dtk_b  : dtk_a,  e_dtk[k]);
            chk($sformatf("d%0d_hit", k),  k ? ahit_b : ahit_a, e_hit[k]);
            chk($sformatf("d%0d_lerr", k), k ? lerr_b : lerr_a, e_lerr[k]);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: the model samples the inputs at the edge, and the outputs
    // are compared 1 time unit later. The caller changes inputs after that.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all();
        if (ahit_a === 1'b1) hits_a++;
        if (stk_a === 1'b1) stks_a++;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load     = 1'b1;
        load_hr  = 5'(h);
        load_min = 6'(m);
        load_sec = 6'(s);
        cycle();
        load     = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();

        // Held in reset: everything zero.
        repeat (3) cycle();
        rst = 1'b1;

        // 1: run 8 cycles from reset -> sec=2, two sec_ticks.
        en = 1'b1;
        stks_a = 0;
        repeat (8) cycle();
        chk("t1_sec", sec_a, 2);
        chk("t1_ticks", stks_a, 2);

        // 2: midnight rollover, all four ticks together on the second tick.
        do_load(23, 59, 58);
        repeat (8) cycle();
        chk("t2_day", dtk_a, 1);
        chk("t2_hr_tick", htk_a, 1);
        chk("t2_time", {hr_a, min_a, sec_a}, 0);

        // 3: rejected load leaves time alone; a valid load is exact.
        en = 1'b0;
        do_load(1, 2, 60);
        chk("t3_lerr", lerr_a, 1);
        chk("t3_unchanged", {hr_a, min_a, sec_a}, 0);
        do_load(24, 0, 0);
        do_load(12, 34, 56);
        chk("t3_load", {hr_a, min_a, sec_a}, {5'd12, 6'd34, 6'd56});
        en = 1'b1;
        repeat (5) cycle();

        // 4: alarm on rollover, never on load, not when disabled.
        alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd30;
        do_load(7, 29, 59);
        hits_a = 0;
        repeat (4) cycle();
        chk("t4_hit", hits_a, 1);
        hits_a = 0;
        do_load(7, 30, 0);
        repeat (2) cycle();
        chk("t4_load_nohit", hits_a, 0);
        do_load(7, 29, 59);
        alarm_en = 1'b0;
        repeat (4) cycle();
        chk("t4_dis_nohit", hits_a, 0);

        // 5: freeze mid-prescale, then resume.
        repeat (2) cycle();
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        repeat (6) cycle();

        // 6: asynchronous reset part-way through a cycle.
        do_load(5, 6, 7);
        repeat (3) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_a", {hr_a, min_a, sec_a, stk_a, mtk_a, htk_a, dtk_a, ahit_a, lerr_a}, 0);
        chk("t6_async_b", {hr_b, min_b, sec_b, stk_b, mtk_b, htk_b, dtk_b, ahit_b, lerr_b}, 0);
        model_reset();
        cycle();
        rst = 1'b1;
        repeat (5) cycle();
        chk("t6_div1_sec", sec_b, 5);

        // Randomized run, including near-midnight loads and live alarms.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    do_load($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
                else if ($urandom_range(0, 1) == 0)
                    do_load(23, 59, $urandom_range(56, 59));
                else
                    do_load($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(50, 59));
            end
            if ($urandom_range(0, 19) == 0) begin
                int nm;
                nm = ((t_m[0] / SPM) + 1) % (MPH * HPD);
                alarm_en  = ($urandom_range(0, 3) != 0);
                alarm_hr  = 5'(nm / MPH);
                alarm_min = 6'(nm % MPH);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
